serial_adder: RTL and testbench

Bit-serial N-bit adder built around a single full-adder cell. It accepts two operands and a carry-in on a start strobe. It adds them LSB-first, one bit per clock, holding the ripple carry in a flip-flop, and presents the full sum and carry-out with a one-cycle done pulse. It is the sequential consumer of the lab's full-adder stage: it feeds the cell its a/b/c inputs each cycle and captures the cell's sum/carry outputs.

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_full_adder_cell.sv | 13 +
 rtl/serial_adder.sv | 110 +++++++++++
 tb/tb_serial_adder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and default width.
package serial_adder_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// Single combinational full-adder cell; the serial adder reuses it once per bit.
module full_adder_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_sum,
  output logic o_carry
);

  assign o_sum   = i_a ^ i_b ^ i_c;
  assign o_carry = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: LSB-first through one full-adder cell, carry held in a flop,
// result shifted into the sum register from the MSB end.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CW-1:0]    r_count;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic             w_fa_sum;
  logic             w_fa_carry;

  full_adder_cell u_cell (
    .i_a     (r_opa[0]),
    .i_b     (r_opb[0]),
    .i_c     (r_carry),
    .o_sum   (w_fa_sum),
    .o_carry (w_fa_carry)
  );

  // State register plus status flags registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == IDLE);
      r_busy  <= (w_state_nxt == RUN);
      r_done  <= (w_state_nxt == DONE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_nxt = RUN;
      RUN:     if (r_count == CW'(WIDTH - 1)) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: capture on accepted start, then one shift/add step per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_opa   <= i_a;
            r_opb   <= i_b;
            r_carry <= i_cin;
            r_count <= '0;
          end
        end
        RUN: begin
          r_opa   <= {1'b0, r_opa[WIDTH-1:1]};
          r_opb   <= {1'b0, r_opb[WIDTH-1:1]};
          r_sum   <= {w_fa_sum, r_sum[WIDTH-1:1]};
          r_carry <= w_fa_carry;
          r_count <= r_count + CW'(1);
          // Final carry lands alongside the last sum bit so both are valid with done.
          if (w_state_nxt == DONE) r_cout <= w_fa_carry;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_sum   = r_sum;
  assign o_cout  = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8 and WIDTH=3.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       st8, ci8, rdy8, bsy8, dn8, co8;
  logic [7:0] a8, b8, sum8;
  logic       st3, ci3, rdy3, bsy3, dn3, co3;
  logic [2:0] a3, b3, sum3;

  int n_cmp = 0;
  int n_err = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .i_start(st8), .i_a(a8), .i_b(b8), .i_cin(ci8),
    .o_ready(rdy8), .o_busy(bsy8), .o_done(dn8), .o_sum(sum8), .o_cout(co8)
  );

  serial_adder #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .i_start(st3), .i_a(a3), .i_b(b3), .i_cin(ci3),
    .o_ready(rdy3), .o_busy(bsy3), .o_done(dn3), .o_sum(sum3), .o_cout(co3)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Observes dut8 for ncyc negedges after a start has been set up; k is the count
  // of rising edges since the start edge minus one. Optionally pulses start at pulse_k.
  task automatic obs8(input int ncyc, input int pulse_k, output int first_done,
                      output int busy_n, output int done_n,
                      output logic [7:0] s, output logic c);
    first_done = -1; busy_n = 0; done_n = 0; s = '0; c = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (k == 0) begin st8 = 1'b0; a8 = ~a8; b8 = ~b8; ci8 = ~ci8; end
      if (k == pulse_k) begin st8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; end
      if (k == pulse_k + 1) st8 = 1'b0;
      if (bsy8) busy_n++;
      if (dn8) begin
        done_n++;
        if (first_done < 0) begin first_done = k; s = sum8; c = co8; end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; st8 = 0; a8 = '0; b8 = '0; ci8 = 0; st3 = 0; a3 = '0; b3 = '0; ci3 = 0;
    #12;
    n_cmp++;
    if ({rdy8, bsy8, dn8, sum8, co8} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL reset_in_reset: got rdy/bsy/dn/sum/co=%b/%b/%b/%h/%b want 1/0/0/00/0",
               rdy8, bsy8, dn8, sum8, co8);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({rdy8, bsy8, dn8, sum8, co8} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL reset_idle8: got rdy/bsy/dn/sum/co=%b/%b/%b/%h/%b want 1/0/0/00/0",
               rdy8, bsy8, dn8, sum8, co8);
    end
    n_cmp++;
    if ({rdy3, bsy3, dn3, sum3, co3} !== {1'b1, 1'b0, 1'b0, 3'h0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_idle3: got rdy/bsy/dn/sum/co=%b/%b/%b/%h/%b want 1/0/0/0/0",
               rdy3, bsy3, dn3, sum3, co3);
    end
  endtask

  task automatic test_basic;
    int fd, bn, dnn; logic [7:0] s; logic c;
    @(negedge clk); a8 = 8'h3C; b8 = 8'h0F; ci8 = 1'b0; st8 = 1'b1;
    obs8(14, -1, fd, bn, dnn, s, c);
    n_cmp++;
    if (fd !== 8) begin n_err++; $display("FAIL basic_latency: done at %0d want 8", fd); end
    n_cmp++;
    if (bn !== 8) begin n_err++; $display("FAIL basic_busy: busy cycles %0d want 8", bn); end
    n_cmp++;
    if (dnn !== 1) begin n_err++; $display("FAIL basic_done_cnt: %0d want 1", dnn); end
    n_cmp++;
    if ({c, s} !== 9'h04B) begin
      n_err++; $display("FAIL basic_result: cout/sum=%b/%h want 0/4b", c, s);
    end
    n_cmp++;
    if ({c, s} !== {co8, sum8} || rdy8 !== 1'b1) begin
      n_err++; $display("FAIL basic_hold: cout/sum=%b/%h rdy=%b want 0/4b rdy=1", co8, sum8, rdy8);
    end
  endtask

  task automatic test_back_to_back;
    int d0, d1, dnn; logic [8:0] r0, r1;
    d0 = -1; d1 = -1; dnn = 0; r0 = '0; r1 = '0;
    @(negedge clk); a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b0; st8 = 1'b1;
    for (int k = 0; k < 26; k++) begin
      @(negedge clk);
      if (k == 0) begin a8 = 8'hA5; b8 = 8'h5A; ci8 = 1'b1; end
      if (k == 10) st8 = 1'b0;
      if (dn8) begin
        dnn++;
        if (d0 < 0) begin d0 = k; r0 = {co8, sum8}; end
        else if (d1 < 0) begin d1 = k; r1 = {co8, sum8}; end
      end
    end
    n_cmp++;
    if (d0 !== 8 || d1 !== 18) begin
      n_err++; $display("FAIL b2b_timing: dones at %0d,%0d want 8,18", d0, d1);
    end
    n_cmp++;
    if (r0 !== 9'h100) begin n_err++; $display("FAIL b2b_first: %h want 100", r0); end
    n_cmp++;
    if (r1 !== 9'h100) begin n_err++; $display("FAIL b2b_second: %h want 100", r1); end
    n_cmp++;
    if (dnn !== 2) begin n_err++; $display("FAIL b2b_done_cnt: %0d want 2", dnn); end
  endtask

  task automatic test_ignored_start;
    int fd, bn, dnn; logic [7:0] s; logic c;
    @(negedge clk); a8 = 8'h12; b8 = 8'h34; ci8 = 1'b0; st8 = 1'b1;
    obs8(18, 2, fd, bn, dnn, s, c);
    n_cmp++;
    if ({c, s} !== 9'h046) begin
      n_err++; $display("FAIL ignore_result: cout/sum=%b/%h want 0/46", c, s);
    end
    n_cmp++;
    if (dnn !== 1 || fd !== 8) begin
      n_err++; $display("FAIL ignore_done: count %0d at %0d want 1 at 8", dnn, fd);
    end
  endtask

  task automatic test_reset_mid_run;
    int fd, bn, dnn, late; logic [7:0] s; logic c;
    @(negedge clk); a8 = 8'h55; b8 = 8'h33; ci8 = 1'b0; st8 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) st8 = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rdy8, bsy8, dn8, sum8, co8} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL midrst_outputs: rdy/bsy/dn/sum/co=%b/%b/%b/%h/%b want 1/0/0/00/0",
               rdy8, bsy8, dn8, sum8, co8);
    end
    @(negedge clk); rst_n = 1'b1;
    late = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (dn8 || bsy8) late++;
    end
    n_cmp++;
    if (late !== 0) begin n_err++; $display("FAIL midrst_no_done: %0d active cycles want 0", late); end
    a8 = 8'h01; b8 = 8'h01; ci8 = 1'b0; st8 = 1'b1;
    obs8(12, -1, fd, bn, dnn, s, c);
    n_cmp++;
    if ({c, s} !== 9'h002 || fd !== 8) begin
      n_err++; $display("FAIL midrst_after: cout/sum=%b/%h at %0d want 0/02 at 8", c, s, fd);
    end
  endtask

  task automatic test_w3_exhaustive;
    int fd, dnn; logic [3:0] got, exp_v;
    for (int ia = 0; ia < 8; ia++)
      for (int ib = 0; ib < 8; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          @(negedge clk);
          a3 = 3'(ia); b3 = 3'(ib); ci3 = 1'(ic); st3 = 1'b1;
          exp_v = 4'(ia) + 4'(ib) + 4'(ic);
          fd = -1; dnn = 0; got = '0;
          for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) begin st3 = 1'b0; a3 = ~a3; b3 = ~b3; ci3 = ~ci3; end
            if (dn3) begin
              dnn++;
              if (fd < 0) begin fd = k; got = {co3, sum3}; end
            end
          end
          n_cmp++;
          if (got !== exp_v) begin
            n_err++; $display("FAIL w3_sum a=%0d b=%0d c=%0d: got %0d want %0d", ia, ib, ic, got, exp_v);
          end
          n_cmp++;
          if (dnn !== 1 || fd !== 3) begin
            n_err++; $display("FAIL w3_done a=%0d b=%0d c=%0d: count %0d at %0d want 1 at 3",
                              ia, ib, ic, dnn, fd);
          end
        end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_ignored_start;
    test_reset_mid_run;
    test_w3_exhaustive;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
